// File: rtl/cpu_types_pkg.sv
// Shared cache-bus types: RAM handshake states and the memory arbiter FSM encoding.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [2:0] {
      ARB_IDLE   = 3'd0,
      ARB_IREAD  = 3'd1,
      ARB_DREAD  = 3'd2,
      ARB_DWRITE = 3'd3,
      ARB_ABORT  = 3'd4
   } arb_state_t;

   localparam int ARB_TIMEOUT_DEF = 16;
   localparam int ARB_STAT_W_DEF  = 16;

endpackage

// File: rtl/mem_arbiter_ctrl_sat_counter.sv
// Saturating up-counter used for per-requester transaction statistics.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: hold at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Memory-side arbiter between dcache and icache: grants one single-word request at a
// time, drives the RAM port, returns data/wait handshakes, and aborts on RAM error or stall.
module mem_arbiter_ctrl
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEF,
   parameter int STAT_W  = ARB_STAT_W_DEF
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [31:0]       iaddr,
   output logic              iwait,
   output logic [31:0]       iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [31:0]       daddr,
   input  logic [31:0]       dstore,
   output logic              dwait,
   output logic [31:0]       dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [31:0]       ramaddr,
   output logic [31:0]       ramstore,
   input  logic [31:0]       ramload,
   input  logic [1:0]        ramstate,
   output logic              err,
   output logic [STAT_W-1:0] icount,
   output logic [STAT_W-1:0] dcount
);

   localparam int                WDOG_W   = $clog2(TIMEOUT);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

   arb_state_t        state_q, state_d;
   logic              last_d_q, last_d_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   ramstate_t         rs_s;
   logic              req_live_s;
   logic              serve_s;
   logic              i_inc_s;
   logic              d_inc_s;

   assign rs_s    = ramstate_t'(ramstate);
   assign serve_s = (state_q == ARB_IREAD) || (state_q == ARB_DREAD) || (state_q == ARB_DWRITE);

   // Grant, RAM port decode, handshakes and watchdog next-state.
   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      wdog_d     = wdog_q;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = 32'h0000_0000;
      ramstore   = 32'h0000_0000;
      iwait      = 1'b1;
      dwait      = 1'b1;
      iload      = 32'h0000_0000;
      dload      = 32'h0000_0000;
      err        = 1'b0;
      req_live_s = 1'b0;
      i_inc_s    = 1'b0;
      d_inc_s    = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            wdog_d = {WDOG_W{1'b0}};
            // The icache gets its turn when the dcache won the previous grant.
            if ((dREN || dWEN) && iREN && last_d_q) begin
               state_d  = ARB_IREAD;
               last_d_d = 1'b0;
            end else if (dWEN) begin
               state_d  = ARB_DWRITE;
               last_d_d = 1'b1;
            end else if (dREN) begin
               state_d  = ARB_DREAD;
               last_d_d = 1'b1;
            end else if (iREN) begin
               state_d  = ARB_IREAD;
               last_d_d = 1'b0;
            end else begin
               state_d  = ARB_IDLE;
            end
         end
         ARB_DREAD: begin
            req_live_s = dREN;
            ramREN     = dREN;
            ramaddr    = daddr;
            if (dREN && (rs_s == ACCESS)) begin
               dwait   = 1'b0;
               dload   = ramload;
               d_inc_s = 1'b1;
            end else begin
               dwait   = 1'b1;
            end
         end
         ARB_DWRITE: begin
            req_live_s = dWEN;
            ramWEN     = dWEN;
            ramaddr    = daddr;
            ramstore   = dstore;
            if (dWEN && (rs_s == ACCESS)) begin
               dwait   = 1'b0;
               d_inc_s = 1'b1;
            end else begin
               dwait   = 1'b1;
            end
         end
         ARB_IREAD: begin
            req_live_s = iREN;
            ramREN     = iREN;
            ramaddr    = iaddr;
            if (iREN && (rs_s == ACCESS)) begin
               iwait   = 1'b0;
               iload   = ramload;
               i_inc_s = 1'b1;
            end else begin
               iwait   = 1'b1;
            end
         end
         ARB_ABORT: begin
            err     = 1'b1;
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      // A dropped request ends the serve silently; otherwise wait for ACCESS or give up.
      if (serve_s) begin
         if (!req_live_s) begin
            state_d = ARB_IDLE;
         end else if (rs_s == ACCESS) begin
            state_d = ARB_IDLE;
         end else if ((rs_s == ERROR) || (wdog_q == WDOG_MAX)) begin
            state_d = ARB_ABORT;
         end else begin
            wdog_d  = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
         end
      end else begin
         wdog_d = wdog_d;
      end
   end

   // FSM, fairness and watchdog registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= ARB_IDLE;
         last_d_q <= 1'b0;
         wdog_q   <= {WDOG_W{1'b0}};
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         wdog_q   <= wdog_d;
      end
   end

   sat_counter #(.W(STAT_W)) u_icount (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (i_inc_s),
      .q    (icount)
   );

   sat_counter #(.W(STAT_W)) u_dcount (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (d_inc_s),
      .q    (dcount)
   );

endmodule
